// File: rtl/ifetch_pkg.sv
// Shared widths and the fetch-buffer entry type for the instruction fetch unit.
package ifetch_pkg;

  localparam int XLEN    = 32;
  localparam int ILEN    = 32;
  localparam int ROM_AW  = 10;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous fetch buffer: power-of-two depth, flush wins over push/pop,
// push accepted when full if a pop happens in the same cycle.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output fetch_entry_t head_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t   mem_q [DEPTH];
  logic [PW-1:0]  rd_ptr_q;
  logic [PW-1:0]  wr_ptr_q;
  logic [CW-1:0]  count_q;
  logic           do_push_s;
  logic           do_pop_s;

  assign empty_o   = (count_q == CW'(0));
  assign full_o    = (count_q == CW'(DEPTH));
  assign do_pop_s  = pop_i && !empty_o;
  assign do_push_s = push_i && (!full_o || do_pop_s);
  assign head_o    = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is cleared on reset so the head reads zero while held in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push_s && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: PC register, ROM addressing and redirect control
// around an ifetch_fifo. Optional IFETCH_HALT_ON_ZERO_EN stops fetch on a zero word.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [ILEN-1:0]   rom_data,
  output logic [ILEN-1:0]   instr,
  output logic [XLEN-1:0]   instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              halted
);

  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] fetch_pc_d;
  logic            fifo_full_s;
  logic            fifo_empty_s;
  logic            fifo_push_s;
  logic            fifo_pop_s;
  logic            fetch_slot_s;
  logic            zero_word_s;
  logic            redirect_lsb_unused;
  fetch_entry_t    push_entry_s;
  fetch_entry_t    head_s;

  assign rom_addr            = fetch_pc_q[ROM_AW+1:2];
  assign instr_valid         = !fifo_empty_s;
  assign instr               = head_s.instr;
  assign instr_pc            = head_s.pc;
  assign push_entry_s        = '{pc: fetch_pc_q, instr: rom_data};
  assign redirect_lsb_unused = ^redirect_pc[1:0];
  assign fetch_slot_s        = (!fifo_full_s || (instr_valid && instr_ready)) && !halted;

  // Fetch/pop decision; a redirect discards whatever this cycle would have done.
  always_comb begin
    fifo_push_s = 1'b0;
    fifo_pop_s  = 1'b0;
    fetch_pc_d  = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = word_align(redirect_pc);
    end else begin
      fifo_pop_s = instr_valid && instr_ready;
      if (fetch_slot_s && !zero_word_s) begin
        fifo_push_s = 1'b1;
        fetch_pc_d  = fetch_pc_q + XLEN'(PC_STEP);
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fetch_pc_q <= RESET_PC;
    else        fetch_pc_q <= fetch_pc_d;
  end

`ifdef IFETCH_HALT_ON_ZERO_EN
  logic halted_q;
  logic halted_d;

  assign zero_word_s = (rom_data == ILEN'(0));
  assign halted      = halted_q;

  // Halt latches on a zero fetch and only a redirect or reset releases it.
  always_comb begin
    halted_d = halted_q;
    if (redirect_valid)                   halted_d = 1'b0;
    else if (fetch_slot_s && zero_word_s) halted_d = 1'b1;
    else                                  halted_d = halted_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halted_q <= 1'b0;
    else        halted_q <= halted_d;
  end
`else
  assign zero_word_s = 1'b0;
  assign halted      = 1'b0;
`endif

  ifetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (redirect_valid),
    .push_i      (fifo_push_s),
    .push_data_i (push_entry_s),
    .pop_i       (fifo_pop_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .head_o      (head_s)
  );

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios then randomized
// ready/redirect/reset traffic against a queue-based reference model.
module tb_ifetch_unit;
  import ifetch_pkg::*;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  rom_addr;
  logic [31:0] rom_data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halted;

  logic [31:0] rom [1024];
  assign rom_data = rom[rom_addr];

  ifetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: buffer as a queue of {pc, instr}, plus fetch pc and halt flag.
  logic [63:0] mq[$];
  logic [31:0] mpc;
  logic        mhalt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpc   = RST_PC;
    mhalt = 1'b0;
  endtask

  // Applies the fetch rules for one rising edge using the inputs now applied.
  task automatic model_edge();
    logic        pop;
    logic        slot;
    logic [31:0] w;
    if (redirect_valid) begin
      mq.delete();
      mpc   = {redirect_pc[31:2], 2'b00};
      mhalt = 1'b0;
    end else begin
      pop  = (mq.size() > 0) && instr_ready;
      slot = ((mq.size() < DEPTH) || pop) && !mhalt;
      w    = rom[mpc[11:2]];
      if (pop) void'(mq.pop_front());
      if (slot) begin
`ifdef IFETCH_HALT_ON_ZERO_EN
        if (w == 32'h0) begin
          mhalt = 1'b1;
        end else begin
          mq.push_back({mpc, w});
          mpc = mpc + 32'd4;
        end
`else
        mq.push_back({mpc, w});
        mpc = mpc + 32'd4;
`endif
      end
    end
  endtask

  task automatic compare_all();
    check_eq("instr_valid", {31'd0, instr_valid}, {31'd0, (mq.size() > 0)});
    if (mq.size() > 0) begin
      check_eq("instr", instr, mq[0][31:0]);
      check_eq("instr_pc", instr_pc, mq[0][63:32]);
    end
    check_eq("rom_addr", {22'd0, rom_addr}, {22'd0, mpc[11:2]});
    check_eq("halted", {31'd0, halted}, {31'd0, mhalt});
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("rst_instr", instr, 32'd0);
    check_eq("rst_instr_pc", instr_pc, 32'd0);
    check_eq("rst_halted", {31'd0, halted}, 32'd0);
    check_eq("rst_rom_addr", {22'd0, rom_addr}, {22'd0, RST_PC[11:2]});
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic saw39;

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 32'h0;
    for (int i = 2; i < 39; i++) rom[i] = $urandom | 32'h1;
    rom[0] = 32'h0780_0793;
    rom[1] = 32'h0280_0813;
    #2;

    // Reset release with ready high.
    instr_ready = 1'b1;
    do_reset();
    step();
    check_eq("first_instr", instr, 32'h0780_0793);
    check_eq("first_pc", instr_pc, 32'h0);
    step();
    check_eq("second_instr", instr, 32'h0280_0813);
    check_eq("second_pc", instr_pc, 32'h4);

    // Back-pressure fills the buffer and freezes fetch.
    instr_ready = 1'b0;
    do_reset();
    repeat (5) step();
    check_eq("bp_instr", instr, 32'h0780_0793);
    check_eq("bp_rom_addr", {22'd0, rom_addr}, DEPTH);

    // Redirect while full.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0023;
    step();
    check_eq("redir_flush", {31'd0, instr_valid}, 32'd0);
    check_eq("redir_rom_addr", {22'd0, rom_addr}, 32'd8);
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    step();
    check_eq("redir_valid", {31'd0, instr_valid}, 32'd1);
    check_eq("redir_pc", instr_pc, 32'h20);

    // Stream into the zero region at word 39.
    do_reset();
    saw39 = 1'b0;
    for (int i = 0; i < 45; i++) begin
      step();
      if (instr_valid && instr_pc == 32'h9C) begin
        saw39 = 1'b1;
        check_eq("word39_instr", instr, 32'h0);
        check_eq("word39_halted", {31'd0, halted}, 32'd0);
      end
    end
`ifdef IFETCH_HALT_ON_ZERO_EN
    check_eq("halt_set", {31'd0, halted}, 32'd1);
    check_eq("halt_novalid", {31'd0, instr_valid}, 32'd0);
    check_eq("halt_no39", {31'd0, saw39}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    step();
    redirect_valid = 1'b0;
    step();
    check_eq("resume_valid", {31'd0, instr_valid}, 32'd1);
    check_eq("resume_pc", instr_pc, 32'h0);
`else
    check_eq("word39_seen", {31'd0, saw39}, 32'd1);
`endif

    // Mid-stream reset with a full buffer.
    instr_ready = 1'b0;
    do_reset();
    repeat (4) step();
    do_reset();
    instr_ready = 1'b1;
    step();
    check_eq("mid_rst_pc", instr_pc, RST_PC);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        redirect_valid = 1'b1;
        case ($urandom_range(0, 3))
          0:       redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
          default: redirect_pc = 32'($urandom_range(0, 180));
        endcase
      end else begin
        redirect_valid = 1'b0;
      end
      if ($urandom_range(0, 299) == 0) begin
        redirect_valid = 1'b0;
        do_reset();
      end else begin
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address fetched first after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, fetch buffer entries (legal values 2 and 4).
REQ-003 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port rom_addr, output, 10 bits: word address to the instruction ROM, equal to fetch_pc[11:2].
REQ-006 SHALL have port rom_data, input, 32 bits: combinational ROM word for rom_addr, valid in the same cycle.
REQ-007 SHALL have port instr, output, 32 bits: instruction at the buffer head.
REQ-008 SHALL have port instr_pc, output, 32 bits: byte PC of instr.
REQ-009 SHALL have port instr_valid, output, 1 bit: buffer non-empty.
REQ-010 SHALL have port instr_ready, input, 1 bit: decode accepts the head this cycle.
REQ-011 SHALL have port redirect_valid, input, 1 bit: branch/jump taken, flush and refetch.
REQ-012 SHALL have port redirect_pc, input, 32 bits: new fetch byte address.
REQ-013 SHALL have port halted, output, 1 bit: fetch stopped (see Configuration).

Function
REQ-014 SHALL push {fetch_pc, rom_data} into the buffer and advance fetch_pc by 4 on a clock edge where the buffer is not full (or is full with a pop in the same cycle), halted=0 and redirect_valid=0.
REQ-015 SHALL pop the head on an edge where instr_valid and instr_ready are both 1; instr/instr_pc hold while instr_valid=1 and instr_ready=0.
REQ-016 SHALL give one cycle latency from push to instr_valid, with instr and instr_pc driven from registers only.
REQ-017 SHALL, on an edge with redirect_valid=1, empty the buffer, discard any concurrent push and pop, load fetch_pc={redirect_pc[31:2],2'b00}, and clear halted.
REQ-018 SHALL present the first redirected instruction with instr_valid=1 two edges after the redirect edge.
REQ-019 SHALL increment fetch_pc modulo 2^32; rom_addr wraps from 1023 to 0 naturally.
REQ-020 SHALL never raise instr_valid for an entry pushed before a redirect.
REQ-021 SHALL sustain one instruction per cycle when instr_ready is held at 1.

Reset
REQ-022 SHALL, while rst_n=0, hold fetch_pc=RESET_PC, keep the buffer empty, and drive instr_valid=0, instr=0, instr_pc=0, halted=0.
REQ-023 SHALL push the word at RESET_PC on the first edge after rst_n rises; instr_valid rises after that edge.
REQ-024 SHALL abort an in-flight stream on mid-operation reset, with no entry surviving.

Configuration
REQ-025 SHALL support macro IFETCH_HALT_ON_ZERO_EN: when defined, a fetched rom_data==32'h0 is not pushed, fetch_pc does not advance, and halted goes to 1 on that edge, holding until redirect or reset.
REQ-026 SHALL, when IFETCH_HALT_ON_ZERO_EN is undefined, push zero words as ordinary instructions and tie halted to 0.

Structure
REQ-027 SHALL take from package ifetch_pkg: XLEN=32, ILEN=32, ROM_AW=10, PC_STEP=4, and typedef fetch_entry_t {pc, instr}.
REQ-028 SHALL implement the buffer as sub-module ifetch_fifo (synchronous, parameterised depth, same-cycle push+pop when full, flush input); the control path and PC register stay in ifetch_unit.

Verification
REQ-029 SHALL cover reset release with instr_ready=1: the first edge after rst_n rises gives instr=32'h07800793 with instr_pc=0, and the next edge gives 32'h02800813 with instr_pc=4.
REQ-030 SHALL cover back-pressure: instr_ready=0 for 5 cycles leaves the buffer full (FIFO_DEPTH entries), instr stable at 32'h07800793, and rom_addr frozen at FIFO_DEPTH.
REQ-031 SHALL cover redirect: redirect_pc=32'h0000_0023 while full gives a flush, rom_addr=8 on the next cycle, and instr_pc=32'h20 with instr_valid two edges later, with no stale entries.
REQ-032 SHALL cover halt with the macro defined: streaming to word 39 (ROM default 0) gives halted=1 after instr_pc=0x98 is delivered, with no further valid; a redirect to 0 resumes fetch.
REQ-033 SHALL cover halt without the macro: word 39 is delivered as instr=0 with halted=0.
REQ-034 SHALL cover mid-stream rst_n pulse with a full buffer: instr_valid=0 asynchronously, and after release instr_pc restarts at RESET_PC.
